mac_unit_param: RTL and testbench
=================================

# mac_unit_param

Parametrised, two-stage pipelined multiply-accumulate unit: the next generation of the team's fixed 8-bit MAC. It adds generic operand and accumulator widths, a valid qualifier, signed/unsigned mode, block-length accumulation with a done pulse, a synchronous clear and overflow detection. It sits between a sample source and a consumer that reads the accumulated sum once per block.

## Interface
- DATA_W, 8, operand width in bits (≥2)
- ACC_W, 2*DATA_W+8, accumulator width (≥2*DATA_W)
- BLOCK_LEN, 4, number of valid samples per accumulation block (≥1)
- CNT_W, $clog2(BLOCK_LEN+1), sample counter width
- clock  input  1  single clock; all state updates on rising edge
- reset_p  input  1  reset, asynchronous, active-high
- in_valid  input  1  a/b/signed_mode carry a sample this cycle
- a  input  DATA_W  operand A
- b  input  DATA_W  operand B
- signed_mode  input  1  1: two's-complement operands; 0: unsigned; sampled with the data
- clear  input  1  synchronous accumulator/counter clear
- p  output  2*DATA_W  registered product of the last accepted sample
- p_valid  output  1  p holds a new product this cycle
- s  output  ACC_W  accumulator value
- s_valid  output  1  s updated this cycle
- done  output  1  one-cycle pulse: s holds the completed block sum
- ovf  output  1  sticky overflow flag for the current block

## Operation
- Stage 1: on in_valid, p <= a*b (signed or unsigned per signed_mode); the stage register captures p_valid <= in_valid and the signedness. p holds its value when in_valid=0.
- Stage 2: when the stage-1 valid bit is set, s <= base + ext(p), where ext is a sign extension (signed) or zero extension (unsigned) to ACC_W. base is 0 for the first sample of a block, otherwise s. s_valid is asserted.
- Counter: it increments on each stage-2 update. When the update takes the count to BLOCK_LEN, done is asserted with that update, the counter returns to 0, and the next update starts from base 0. s holds the block sum until that next update.
- ovf: set when a stage-2 addition overflows ACC_W. The check is unsigned carry-out in unsigned mode and two's-complement overflow in signed mode. It stays set until the first update of the next block, or until clear or reset.
- clear: s <= 0, counter <= 0, ovf <= 0, and the stage-1 valid bit is discarded (no stage-2 update). A sample presented with clear is still captured into stage 1 and becomes the first sample of the new block. clear has priority over every stage-2 update.
- Mixing signed_mode within one block is legal. Each product is extended according to its own mode.

## Timing
- Reset values: p=0, p_valid=0, s=0, s_valid=0, done=0, ovf=0, counter=0, stage-1 valid=0.
- A sample accepted at edge k:
  - p and p_valid are visible after edge k.
  - s and s_valid are visible after edge k+1 (latency 2).
  - done and ovf are updated after edge k+1, together with s.
- Back-to-back samples are accepted every cycle (throughput 1/cycle). There are no stalls and no backpressure.
- reset_p asserted mid-block: all state returns to reset values immediately and any in-flight sample is lost.
- BLOCK_LEN=1: done pulses with every update, and each s equals the extended product.

## Configuration
- MAC_SATURATE_EN defined: on overflow, s clamps instead of wrapping. Unsigned mode clamps to 2^ACC_W−1. Signed mode clamps to +2^(ACC_W−1)−1 or −2^(ACC_W−1) in the direction of the overflow. ovf is still set.
- Not defined: s wraps modulo 2^ACC_W and ovf is set.

## Structure
- Shared package mac_pkg holds:
  - the function computing the default ACC_W from DATA_W;
  - the saturation min/max constant functions;
  - a typedef for the stage-1 record (product, valid, signedness).
- One natural sub-module, mac_mult_stage, containing the stage-1 multiplier and its pipeline register. The accumulator, counter and flags stay in the top level.

## Test plan
- Reset, then unsigned samples 15×17, 40×45, 47×145, 255×255 on consecutive cycles (defaults) -> p = 255, 1800, 6815, 65025; s = 255, 2055, 8870, 73895; done pulses with s=73895. The next sample restarts s from 0.
- Signed mode, DATA_W=8: a=−3, b=5, then a=−128, b=−128 -> p = 0xFFF1, then 0x4000; s = −15, then 16369.
- ACC_W=16, unsigned 255×255 twice:
  - without MAC_SATURATE_EN -> s=64514, ovf=1;
  - with MAC_SATURATE_EN -> s=65535, ovf=1;
  - ovf clears on the first update of the next block.
- clear asserted together with a new sample while one sample is in flight -> the in-flight sample is dropped, s=0, and the new sample becomes the block's first term (s equals its product one cycle later).
- reset_p pulsed asynchronously mid-block (between edges) -> all outputs are 0 immediately. After release, a full block accumulates from zero and done occurs after BLOCK_LEN samples.
- Gaps in in_valid (the pattern 1,0,0,1,1,0,1) -> exactly one done pulse, on the 4th valid sample's stage-2 cycle. s holds its value during the gaps.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and constant helpers for the parametrised MAC unit.
// Operand width is bounded by MAX_PROD_W (DATA_W <= 32) and accumulator width by MAX_ACC_W (ACC_W <= 128).
package mac_pkg;

    localparam int MAX_PROD_W = 64;
    localparam int MAX_ACC_W  = 128;

    typedef struct packed {
        logic [MAX_PROD_W-1:0] prod;
        logic                  valid;
        logic                  is_signed;
    } stage1_t;

    function automatic int default_acc_w(input int data_w);
        return 2 * data_w + 8;
    endfunction

    function automatic logic [MAX_ACC_W-1:0] sat_umax(input int acc_w);
        logic [MAX_ACC_W-1:0] r;
        for (int i = 0; i < MAX_ACC_W; i++) begin
            r[i] = (i < acc_w);
        end
        return r;
    endfunction

    function automatic logic [MAX_ACC_W-1:0] sat_smax(input int acc_w);
        logic [MAX_ACC_W-1:0] r;
        for (int i = 0; i < MAX_ACC_W; i++) begin
            r[i] = (i < acc_w - 1);
        end
        return r;
    endfunction

    function automatic logic [MAX_ACC_W-1:0] sat_smin(input int acc_w);
        logic [MAX_ACC_W-1:0] r;
        for (int i = 0; i < MAX_ACC_W; i++) begin
            r[i] = (i == acc_w - 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Stage 1 of the MAC: signed/unsigned multiplier and its pipeline register.
// The product and signedness are held while no sample is presented; the valid bit follows in_valid_i.
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_p,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              signed_mode_i,
    output stage1_t           rec_o
);

    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [2*DATA_W-1:0] prod;
    stage1_t             rec_d;
    stage1_t             rec_q;

    // Extending both operands to the product width makes one modular multiply serve both modes.
    always_comb begin
        a_ext = {{DATA_W{signed_mode_i & a_i[DATA_W-1]}}, a_i};
        b_ext = {{DATA_W{signed_mode_i & b_i[DATA_W-1]}}, b_i};
        prod  = a_ext * b_ext;
        rec_d = rec_q;
        rec_d.valid = in_valid_i;
        if (in_valid_i) begin
            rec_d.prod                = '0;
            rec_d.prod[2*DATA_W-1:0]  = prod;
            rec_d.is_signed           = signed_mode_i;
        end else begin
            rec_d.prod      = rec_q.prod;
            rec_d.is_signed = rec_q.is_signed;
        end
    end

    // Stage-1 pipeline register.
    always_ff @(posedge clock or posedge reset_p) begin
        if (reset_p) begin
            rec_q <= '0;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign rec_o = rec_q;

endmodule

// File: rtl/mac_unit_param.sv
// Two-stage pipelined multiply-accumulate with block counting, done pulse and sticky overflow.
// Define MAC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module mac_unit_param
    import mac_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = default_acc_w(DATA_W),
    parameter int BLOCK_LEN = 4,
    parameter int CNT_W     = $clog2(BLOCK_LEN + 1)
) (
    input  logic                clock,
    input  logic                reset_p,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                signed_mode,
    input  logic                clear,
    output logic [2*DATA_W-1:0] p,
    output logic                p_valid,
    output logic [ACC_W-1:0]    s,
    output logic                s_valid,
    output logic                done,
    output logic                ovf
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

    stage1_t             st1;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    ext;
    logic [ACC_W-1:0]    base;
    logic [ACC_W:0]      sum_w;
    logic [ACC_W-1:0]    sum_sel;
    logic                add_ovf;
    logic                unused_prod_s;

    logic [ACC_W-1:0]    s_q, s_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                s_valid_q, s_valid_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;

    mac_mult_stage #(
        .DATA_W        (DATA_W)
    ) u_mult (
        .clock         (clock),
        .reset_p       (reset_p),
        .in_valid_i    (in_valid),
        .a_i           (a),
        .b_i           (b),
        .signed_mode_i (signed_mode),
        .rec_o         (st1)
    );

    assign prod          = st1.prod[2*DATA_W-1:0];
    assign unused_prod_s = ^st1.prod;

    // Each product is extended by its own signedness; the first term of a block adds to zero.
    always_comb begin
        ext                = {ACC_W{st1.is_signed & prod[2*DATA_W-1]}};
        ext[2*DATA_W-1:0]  = prod;
        if (cnt_q == '0) begin
            base = '0;
        end else begin
            base = s_q;
        end
        sum_w = {1'b0, base} + {1'b0, ext};
        if (st1.is_signed) begin
            add_ovf = (base[ACC_W-1] == ext[ACC_W-1]) && (sum_w[ACC_W-1] != base[ACC_W-1]);
        end else begin
            add_ovf = sum_w[ACC_W];
        end
    end

`ifdef MAC_SATURATE_EN
    localparam logic [MAX_ACC_W-1:0] UMAX_W = sat_umax(ACC_W);
    localparam logic [MAX_ACC_W-1:0] SMAX_W = sat_smax(ACC_W);
    localparam logic [MAX_ACC_W-1:0] SMIN_W = sat_smin(ACC_W);
    localparam logic [ACC_W-1:0]     UMAX   = UMAX_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0]     SMAX   = SMAX_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0]     SMIN   = SMIN_W[ACC_W-1:0];

    // Signed overflow only happens with like-signed terms, so the product sign gives the direction.
    always_comb begin
        if (!add_ovf) begin
            sum_sel = sum_w[ACC_W-1:0];
        end else if (!st1.is_signed) begin
            sum_sel = UMAX;
        end else if (ext[ACC_W-1]) begin
            sum_sel = SMIN;
        end else begin
            sum_sel = SMAX;
        end
    end
`else
    assign sum_sel = sum_w[ACC_W-1:0];
`endif

    // Stage-2 next state: clear wins over any pending update.
    always_comb begin
        s_d       = s_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        s_valid_d = 1'b0;
        done_d    = 1'b0;
        if (clear) begin
            s_d   = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (st1.valid) begin
            s_d       = sum_sel;
            s_valid_d = 1'b1;
            ovf_d     = ((cnt_q == '0) ? 1'b0 : ovf_q) | add_ovf;
            if (cnt_q == LAST_CNT) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            s_d = s_q;
        end
    end

    // Accumulator, counter and flag registers.
    always_ff @(posedge clock or posedge reset_p) begin
        if (reset_p) begin
            s_q       <= '0;
            cnt_q     <= '0;
            s_valid_q <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            s_q       <= s_d;
            cnt_q     <= cnt_d;
            s_valid_q <= s_valid_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    assign p       = prod;
    assign p_valid = st1.valid;
    assign s       = s_q;
    assign s_valid = s_valid_q;
    assign done    = done_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_mac_unit_param.sv
// Directed scoreboard bench for mac_unit_param: default instance plus a 16-bit accumulator instance.
module tb_mac_unit_param;

    typedef struct packed {
        logic [23:0] s;
        logic        done;
        logic        ovf;
    } s_exp_t;

    logic        clock = 1'b0;
    logic        reset_p;
    logic        in_valid, signed_mode, clear;
    logic [7:0]  a, b;
    logic [15:0] p;
    logic        p_valid;
    logic [23:0] s;
    logic        s_valid, done, ovf;

    logic        in_valid16, clear16;
    logic [7:0]  a16, b16;
    logic [15:0] p16, s16;
    logic        p_valid16, s_valid16, done16, ovf16;

    logic [15:0] pq[$];
    s_exp_t      sq[$];
    logic [15:0] last_p;
    logic [23:0] last_s;
    int          checks = 0;
    int          passes = 0;

    always #5 clock = ~clock;

    mac_unit_param dut (
        .clock(clock), .reset_p(reset_p), .in_valid(in_valid), .a(a), .b(b),
        .signed_mode(signed_mode), .clear(clear), .p(p), .p_valid(p_valid),
        .s(s), .s_valid(s_valid), .done(done), .ovf(ovf)
    );

    mac_unit_param #(.DATA_W(8), .ACC_W(16), .BLOCK_LEN(2)) dut16 (
        .clock(clock), .reset_p(reset_p), .in_valid(in_valid16), .a(a16), .b(b16),
        .signed_mode(1'b0), .clear(clear16), .p(p16), .p_valid(p_valid16),
        .s(s16), .s_valid(s_valid16), .done(done16), .ovf(ovf16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic push_s(input logic [23:0] sv, input logic d, input logic o);
        s_exp_t e;
        e.s = sv;
        e.done = d;
        e.ovf = o;
        sq.push_back(e);
    endtask

    task automatic sample_main();
        s_exp_t e;
        if (p_valid) begin
            check("p_expected", 64'(pq.size() != 0), 64'd1);
            if (pq.size() != 0) begin
                last_p = pq.pop_front();
                check("p", 64'(p), 64'(last_p));
            end
        end else begin
            check("p_hold", 64'(p), 64'(last_p));
        end
        if (s_valid) begin
            check("s_expected", 64'(sq.size() != 0), 64'd1);
            if (sq.size() != 0) begin
                e = sq.pop_front();
                last_s = e.s;
                check("s", 64'(s), 64'(e.s));
                check("done", 64'(done), 64'(e.done));
                check("ovf", 64'(ovf), 64'(e.ovf));
            end
        end else begin
            check("s_hold", 64'(s), 64'(last_s));
            check("done_idle", 64'(done), 64'd0);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] aa, input logic [7:0] bb,
                        input logic m, input logic clr);
        in_valid = v;
        a = aa;
        b = bb;
        signed_mode = m;
        clear = clr;
        @(posedge clock);
        #1;
        sample_main();
    endtask

    initial begin
        reset_p = 1'b1;
        in_valid = 1'b0; a = 8'd0; b = 8'd0; signed_mode = 1'b0; clear = 1'b0;
        in_valid16 = 1'b0; a16 = 8'd0; b16 = 8'd0; clear16 = 1'b0;
        last_p = 16'd0;
        last_s = 24'd0;
        #12;
        check("rst_p", 64'(p), 64'd0);
        check("rst_p_valid", 64'(p_valid), 64'd0);
        check("rst_s", 64'(s), 64'd0);
        check("rst_s_valid", 64'(s_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_s16", 64'(s16), 64'd0);
        reset_p = 1'b0;

        // Unsigned block of four, then a restart from zero.
        pq.push_back(16'd255);  pq.push_back(16'd1800);
        pq.push_back(16'd6815); pq.push_back(16'd65025); pq.push_back(16'd6);
        push_s(24'd255, 1'b0, 1'b0);  push_s(24'd2055, 1'b0, 1'b0);
        push_s(24'd8870, 1'b0, 1'b0); push_s(24'd73895, 1'b1, 1'b0);
        push_s(24'd6, 1'b0, 1'b0);
        step(1'b1, 8'd15, 8'd17, 1'b0, 1'b0);
        step(1'b1, 8'd40, 8'd45, 1'b0, 1'b0);
        step(1'b1, 8'd47, 8'd145, 1'b0, 1'b0);
        step(1'b1, 8'd255, 8'd255, 1'b0, 1'b0);
        step(1'b1, 8'd2, 8'd3, 1'b0, 1'b0);
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        last_s = 24'd0;
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);

        // Signed products.
        pq.push_back(16'hFFF1); pq.push_back(16'h4000);
        push_s(24'hFFFFF1, 1'b0, 1'b0); push_s(24'h003FF1, 1'b0, 1'b0);
        step(1'b1, 8'hFD, 8'h05, 1'b1, 1'b0);
        step(1'b1, 8'h80, 8'h80, 1'b1, 1'b0);
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

        // Clear with a new sample while another is in flight.
        pq.push_back(16'd12); pq.push_back(16'd63);
        push_s(24'd63, 1'b0, 1'b0);
        step(1'b1, 8'd3, 8'd4, 1'b0, 1'b0);
        last_s = 24'd0;
        step(1'b1, 8'd7, 8'd9, 1'b0, 1'b1);
        check("clear_no_update", 64'(s_valid), 64'd0);
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

        // Asynchronous reset between edges with a sample in flight.
        pq.push_back(16'd4);
        step(1'b1, 8'd2, 8'd2, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 reset_p = 1'b1;
        #1;
        check("arst_p", 64'(p), 64'd0);
        check("arst_p_valid", 64'(p_valid), 64'd0);
        check("arst_s", 64'(s), 64'd0);
        check("arst_s_valid", 64'(s_valid), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_ovf", 64'(ovf), 64'd0);
        last_p = 16'd0;
        last_s = 24'd0;
        #1 reset_p = 1'b0;
        pq.push_back(16'd1); pq.push_back(16'd4); pq.push_back(16'd9); pq.push_back(16'd16);
        push_s(24'd1, 1'b0, 1'b0);  push_s(24'd5, 1'b0, 1'b0);
        push_s(24'd14, 1'b0, 1'b0); push_s(24'd30, 1'b1, 1'b0);
        step(1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
        step(1'b1, 8'd2, 8'd2, 1'b0, 1'b0);
        step(1'b1, 8'd3, 8'd3, 1'b0, 1'b0);
        step(1'b1, 8'd4, 8'd4, 1'b0, 1'b0);
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

        // Valid pattern 1,0,0,1,1,0,1: a single done on the fourth sample.
        pq.push_back(16'd100); pq.push_back(16'd40); pq.push_back(16'd25); pq.push_back(16'd3);
        push_s(24'd100, 1'b0, 1'b0); push_s(24'd140, 1'b0, 1'b0);
        push_s(24'd165, 1'b0, 1'b0); push_s(24'd168, 1'b1, 1'b0);
        step(1'b1, 8'd10, 8'd10, 1'b0, 1'b0);
        step(1'b0, 8'd99, 8'd99, 1'b0, 1'b0);
        step(1'b0, 8'd99, 8'd99, 1'b0, 1'b0);
        step(1'b1, 8'd20, 8'd2, 1'b0, 1'b0);
        step(1'b1, 8'd5, 8'd5, 1'b0, 1'b0);
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        step(1'b1, 8'd1, 8'd3, 1'b0, 1'b0);
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

        // 16-bit accumulator overflow, blocks of two.
        in_valid16 = 1'b1; a16 = 8'd255; b16 = 8'd255;
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        check("acc16_p", 64'(p16), 64'd65025);
        check("acc16_p_valid", 64'(p_valid16), 64'd1);
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        check("acc16_s1", 64'(s16), 64'd65025);
        check("acc16_ovf1", 64'(ovf16), 64'd0);
        a16 = 8'd1; b16 = 8'd1;
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
`ifdef MAC_SATURATE_EN
        check("acc16_s2", 64'(s16), 64'd65535);
`else
        check("acc16_s2", 64'(s16), 64'd64514);
`endif
        check("acc16_ovf2", 64'(ovf16), 64'd1);
        check("acc16_done2", 64'(done16), 64'd1);
        in_valid16 = 1'b0;
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        check("acc16_s3", 64'(s16), 64'd1);
        check("acc16_s_valid3", 64'(s_valid16), 64'd1);
        check("acc16_ovf3", 64'(ovf16), 64'd0);
        check("acc16_done3", 64'(done16), 64'd0);

        check("pq_drained", 64'(pq.size()), 64'd0);
        check("sq_drained", 64'(sq.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
